// File: rtl/annealer_pkg.sv
// Shared constants and state encoding for the UART-to-RAM command loader.
package annealer_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] OP_WRITE  = 8'h57;
   localparam logic [7:0] OP_READ   = 8'h52;
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;

   typedef enum logic [3:0] {
      S_IDLE,
      S_OP,
      S_AH,
      S_AL,
      S_LEN,
      S_WDATA,
      S_WSTROBE,
      S_RCHK,
      S_RFETCH,
      S_RWAIT,
      S_RSEND,
      S_TXCHK,
      S_ACK
   } ldr_state_e;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/word_shift_reg.sv
// Assembles a RAM word from bytes (MSB first) and serialises it back out.
module word_shift_reg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              shin_i,
   input  logic [7:0]        byte_i,
   input  logic              shout_i,
   output logic [DATA_W-1:0] word_o,
   output logic [7:0]        msb_o,
   output logic              last_o
);

   localparam int BYTES = DATA_W / 8;
   localparam int CW    = $clog2(BYTES) + 1;
   localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [DATA_W-1:0] word_q, word_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         word_d = data_i;
         cnt_d  = '0;
      end else if (clr_i) begin
         cnt_d = '0;
      end else if (shin_i) begin
         word_d = (word_q << 8) | DATA_W'(byte_i);
         cnt_d  = cnt_q + ONE;
      end else if (shout_i) begin
         word_d = word_q << 8;
         cnt_d  = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign word_o = word_q;
   assign msb_o  = word_q[DATA_W-1 -: 8];
   assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_ram_loader.sv
// Framed byte-stream command engine: burst RAM writes and reads over the UART.
module uart_ram_loader
   import annealer_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 500000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic [7:0]        err_count
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0]     TMO_ONE  = TW'(1);
   localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

   ldr_state_e state_q, state_d;

   logic [7:0]        chk_q, chk_d;
   logic [7:0]        txchk_q, txchk_d;
   logic [7:0]        err_q, err_d;
   logic [7:0]        ah_q, ah_d;
   logic [7:0]        ack_q, ack_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [8:0]        len_q, len_d;
   logic              wr_q, wr_d;
   logic [TW-1:0]     tmo_q, tmo_d;

   logic              sr_clr, sr_load, sr_shin, sr_shout;
   logic [DATA_W-1:0] sr_word;
   logic [7:0]        sr_msb;
   logic              sr_last;
   logic [15:0]       frame_addr;
   logic              tmo_run;

   word_shift_reg #(.DATA_W(DATA_W)) u_sr (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (sr_clr),
      .load_i  (sr_load),
      .data_i  (ram_rdata),
      .shin_i  (sr_shin),
      .byte_i  (rx_data),
      .shout_i (sr_shout),
      .word_o  (sr_word),
      .msb_o   (sr_msb),
      .last_o  (sr_last)
   );

   always_comb begin
      state_d  = state_q;
      chk_d    = chk_q;
      txchk_d  = txchk_q;
      err_d    = err_q;
      ah_d     = ah_q;
      ack_d    = ack_q;
      addr_d   = addr_q;
      len_d    = len_q;
      wr_d     = wr_q;
      sr_clr   = 1'b0;
      sr_load  = 1'b0;
      sr_shin  = 1'b0;
      sr_shout = 1'b0;
      ram_we   = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      frame_addr = {ah_q, rx_data};
      tmo_run = state_q inside {S_OP, S_AH, S_AL, S_LEN, S_WDATA, S_RCHK};
      tmo_d   = (rx_valid || !tmo_run) ? '0 : tmo_q + TMO_ONE;

      unique case (state_q)
         S_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
               chk_d   = 8'h00;
               state_d = S_OP;
            end
         end
         S_OP: begin
            if (rx_valid) begin
               chk_d = rx_data;
               if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                  wr_d    = (rx_data == OP_WRITE);
                  state_d = S_AH;
               end else begin
                  err_d   = sat_inc(err_q);
                  state_d = S_IDLE;
               end
            end
         end
         S_AH: begin
            if (rx_valid) begin
               chk_d   = chk_q ^ rx_data;
               ah_d    = rx_data;
               state_d = S_AL;
            end
         end
         S_AL: begin
            if (rx_valid) begin
               chk_d   = chk_q ^ rx_data;
               addr_d  = frame_addr[ADDR_W-1:0];
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (rx_valid) begin
               chk_d   = chk_q ^ rx_data;
               len_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
               sr_clr  = 1'b1;
               state_d = wr_q ? S_WDATA : S_RCHK;
            end
         end
         S_WDATA: begin
            if (rx_valid) begin
               chk_d   = chk_q ^ rx_data;
               sr_shin = 1'b1;
               if (sr_last) state_d = S_WSTROBE;
            end
         end
         S_WSTROBE: begin
            ram_we  = 1'b1;
            addr_d  = addr_q + A_ONE;
            len_d   = len_q - 9'd1;
            sr_clr  = 1'b1;
            state_d = (len_q == 9'd1) ? S_RCHK : S_WDATA;
         end
         S_RCHK: begin
            if (rx_valid) begin
               if (rx_data != chk_q) begin
                  ack_d   = NAK_BYTE;
                  err_d   = sat_inc(err_q);
                  state_d = S_ACK;
               end else if (wr_q) begin
                  ack_d   = ACK_BYTE;
                  state_d = S_ACK;
               end else begin
                  txchk_d = 8'h00;
                  state_d = S_RFETCH;
               end
            end
         end
         S_RFETCH: state_d = S_RWAIT;
         S_RWAIT: begin
            sr_load = 1'b1;
            state_d = S_RSEND;
         end
         S_RSEND: begin
            tx_valid = 1'b1;
            tx_data  = sr_msb;
            if (tx_ready) begin
               txchk_d  = txchk_q ^ sr_msb;
               sr_shout = 1'b1;
               if (sr_last) begin
                  addr_d  = addr_q + A_ONE;
                  len_d   = len_q - 9'd1;
                  state_d = (len_q == 9'd1) ? S_TXCHK : S_RFETCH;
               end
            end
         end
         S_TXCHK: begin
            tx_valid = 1'b1;
            tx_data  = txchk_q;
            if (tx_ready) state_d = S_IDLE;
         end
         S_ACK: begin
            tx_valid = 1'b1;
            tx_data  = ack_q;
            if (tx_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A stalled host abandons the frame silently
      if (tmo_run && !rx_valid && tmo_q == TMO_LAST) begin
         state_d = S_IDLE;
         err_d   = sat_inc(err_q);
         tmo_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         chk_q   <= '0;
         txchk_q <= '0;
         err_q   <= '0;
         ah_q    <= '0;
         ack_q   <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         wr_q    <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         chk_q   <= chk_d;
         txchk_q <= txchk_d;
         err_q   <= err_d;
         ah_q    <= ah_d;
         ack_q   <= ack_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         wr_q    <= wr_d;
         tmo_q   <= tmo_d;
      end
   end

   assign ram_addr  = addr_q;
   assign ram_wdata = sr_word;
   assign busy      = (state_q != S_IDLE);
   assign err_count = err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed + randomized bench for uart_ram_loader with a word-level RAM model.
module tb_uart_ram_loader;

   localparam int DW  = 16;
   localparam int AW  = 10;
   localparam int TMO = 300;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;
   logic          busy;
   logic [7:0]    err_count;

   always #5 clk = ~clk;

   uart_ram_loader #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata), .busy(busy), .err_count(err_count)
   );

   // single-port RAM with registered read
   logic [DW-1:0] mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // reference model: word-addressed contents the host believes are stored
   logic [DW-1:0] ref_mem [int];
   logic [DW-1:0] wq [$];
   logic [7:0]    txq [$];
   int checks = 0;
   int failures = 0;
   int we_cnt = 0;
   int stab_err = 0;
   int err_exp = 0;
   logic pv = 1'b0, pr = 1'b0;
   logic [7:0] pd = 8'h00;

   always @(negedge clk) begin
      if (!reset && pv && !pr && (!tx_valid || tx_data !== pd)) stab_err++;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (ram_we) we_cnt++;
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      tick(3);
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [15:0] a16,
                             input logic [7:0] len, input bit corrupt);
      logic [7:0] c;
      logic [7:0] body [$];
      body = {op, a16[15:8], a16[7:0], len};
      if (op == 8'h57)
         foreach (wq[i]) begin
            body.push_back(wq[i][15:8]);
            body.push_back(wq[i][7:0]);
         end
      c = 8'h00;
      foreach (body[i]) c ^= body[i];
      send_byte(8'hA5);
      foreach (body[i]) send_byte(body[i]);
      send_byte(corrupt ? (c ^ 8'h5A) : c);
   endtask

   task automatic wait_tx(input int n, input string tag);
      int k = 0;
      while (txq.size() < n && k < 3000) begin
         tick(1);
         k++;
      end
      check(tag, 32'(txq.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 3000) begin
         tick(1);
         k++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic do_write(input logic [15:0] a16, input int n, input bit rnd, input bit corrupt);
      int w0;
      if (rnd) begin
         wq.delete();
         for (int i = 0; i < n; i++) wq.push_back(DW'($urandom()));
      end
      for (int i = 0; i < n; i++) ref_mem[(int'(a16) + i) % DEPTH] = wq[i];
      txq.delete();
      w0 = we_cnt;
      tx_ready = 1'b1;
      send_frame(8'h57, a16, n[7:0], corrupt);
      wait_tx(1, "wr_reply_arrives");
      if (txq.size() > 0) check("wr_reply", 32'(txq[0]), corrupt ? 32'h15 : 32'h06);
      check("wr_pulses", 32'(we_cnt - w0), 32'(n));
      if (corrupt) err_exp++;
      wait_idle("wr_idle");
      check("wr_err_count", 32'(err_count), 32'(err_exp));
   endtask

   task automatic do_read(input logic [15:0] a16, input int n, input bit stall);
      logic [7:0] exp [$];
      logic [7:0] xs;
      logic [DW-1:0] w;
      int bad;
      bit ok;
      int k;
      xs = 8'h00;
      for (int i = 0; i < n; i++) begin
         w = ref_mem[(int'(a16) + i) % DEPTH];
         exp.push_back(w[15:8]);
         exp.push_back(w[7:0]);
         xs = xs ^ w[15:8] ^ w[7:0];
      end
      exp.push_back(xs);
      txq.delete();
      tx_ready = 1'b0;
      send_frame(8'h52, a16, n[7:0], 1'b0);
      for (int idx = 0; idx < exp.size(); idx++) begin
         k = 0;
         while (!tx_valid && k < 200) begin
            tick(1);
            k++;
         end
         ok = tx_valid;
         if (!ok) begin
            check("rd_byte_timeout", 32'(ok), 32'd1);
            break;
         end
         if (stall && idx == 2) begin
            tick(20);
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", 32'(tx_data), 32'(exp[2]));
            check("stall_count", 32'(txq.size()), 32'd2);
         end
         tick($urandom_range(0, 2));
         tx_ready = 1'b1;
         tick(1);
         tx_ready = 1'b0;
      end
      tx_ready = 1'b1;
      wait_idle("rd_idle");
      check("rd_len", 32'(txq.size()), 32'(exp.size()));
      bad = 0;
      for (int i = 0; i < exp.size() && i < txq.size(); i++)
         if (txq[i] !== exp[i]) bad++;
      check("rd_bytes", 32'(bad), 32'd0);
      if (txq.size() > 0) check("rd_xor", 32'(txq[txq.size()-1]), 32'(xs));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_err"}, 32'(err_count), 32'd0);
   endtask

   initial begin
      bit ok;
      int k;
      logic [7:0] b;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      reset = 1'b1;
      rx_data = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
      check_zero("reset");

      // idle discards anything but the sync byte
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h00;
         send_byte(b);
      end
      check("idle_ignore_busy", 32'(busy), 32'd0);

      // 1: directed write
      wq = {16'h1234, 16'h5678};
      do_write(16'h0010, 2, 1'b0, 1'b0);
      check("t1_ram10", 32'(mem[10'h010]), 32'h1234);
      check("t1_ram11", 32'(mem[10'h011]), 32'h5678);

      // 2: read back with mid-stream backpressure
      do_read(16'h0010, 2, 1'b1);
      check("t2_stability", 32'(stab_err), 32'd0);

      // 3: bad checksum still writes, then NAKs
      wq = {16'h1234, 16'h5678};
      do_write(16'h0010, 2, 1'b0, 1'b1);
      check("t3_ram10", 32'(mem[10'h010]), 32'h1234);

      // 4: address wrap
      do_write(16'h03FF, 2, 1'b1, 1'b0);
      check("t4_ram3ff", 32'(mem[10'h3FF]), 32'(ref_mem[1023]));
      check("t4_ram000", 32'(mem[10'h000]), 32'(ref_mem[0]));
      do_read(16'h03FF, 2, 1'b0);

      // randomized bursts, high address bits are truncated
      for (int it = 0; it < 4; it++) begin
         logic [15:0] a;
         int n;
         a = 16'($urandom());
         n = $urandom_range(1, 4);
         do_write(a, n, 1'b1, 1'b0);
         do_read(a, n, 1'b0);
      end

      // LEN=0 means 256 words
      do_write(16'h0200, 256, 1'b1, 1'b0);
      do_read(16'h0200, 256, 1'b0);

      // 5: timeout mid-frame
      txq.delete();
      send_byte(8'hA5);
      send_byte(8'h57);
      send_byte(8'h00);
      tick(TMO - 20);
      check("t5_busy_before", 32'(busy), 32'd1);
      tick(40);
      check("t5_busy_after", 32'(busy), 32'd0);
      err_exp++;
      check("t5_err", 32'(err_count), 32'(err_exp));
      check("t5_no_tx", 32'(txq.size()), 32'd0);
      do_write(16'h0123, 3, 1'b1, 1'b0);
      do_read(16'h0123, 3, 1'b0);

      // 6: bad opcode
      send_byte(8'hA5);
      send_byte(8'h33);
      err_exp++;
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_err", 32'(err_count), 32'(err_exp));

      // reset while a read reply is pending
      tx_ready = 1'b0;
      send_frame(8'h52, 16'h0010, 8'd2, 1'b0);
      k = 0;
      while (!tx_valid && k < 200) begin
         tick(1);
         k++;
      end
      ok = tx_valid;
      check("rst_reached_rsend", 32'(ok), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_tx_valid_async", 32'(tx_valid), 32'd0);
      check("rst_busy_async", 32'(busy), 32'd0);
      tick(2);
      reset = 1'b0;
      tx_ready = 1'b1;
      tick(2);
      check_zero("post_reset");
      check("final_stability", 32'(stab_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
